// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Pure definitions: no latency, no flow control.
package if_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DROP
  } fetch_state_t;

  localparam logic [1:0] PCSRC_SEQ    = 2'd0;
  localparam logic [1:0] PCSRC_BRANCH = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  function automatic logic state_is_pending(input fetch_state_t s);
    return (s == REQ) || (s == WAIT) || (s == DROP);
  endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: bubble beats load, otherwise holds; 1-cycle latency.
// No backpressure of its own; the caller gates load/bubble with IF_ID_write.
module if_id_reg
  import if_pkg::*;
#(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_load,
  input  logic                   i_bubble,
  input  logic [INSTR_WIDTH-1:0] i_instr,
  input  logic [PC_WIDTH-1:0]    i_pc_plus4,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [PC_WIDTH-1:0]    o_pc_plus4,
  output logic                   o_valid
);

  logic [INSTR_WIDTH-1:0] r_instr;
  logic [PC_WIDTH-1:0]    r_pc_plus4;
  logic                   r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr    <= INSTR_WIDTH'(NOP_INSTR);
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
    end else if (i_bubble) begin
      r_instr    <= INSTR_WIDTH'(NOP_INSTR);
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
    end else if (i_load) begin
      r_instr    <= i_instr;
      r_pc_plus4 <= i_pc_plus4;
      r_valid    <= 1'b1;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_valid    = r_valid;

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: PC, single-outstanding imem handshake, IF/ID register; >=2 cycles per instr.
// Stalls via pc_write/IF_ID_write park a returned instruction in a hold buffer.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pc_write,
  input  logic                   IF_ID_write,
  input  logic                   flush,
  input  logic [1:0]             pc_source,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic [PC_WIDTH-1:0]    jump_target,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ready,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [PC_WIDTH-1:0]    if_id_pc_plus4,
  output logic                   if_id_valid,
  output logic                   fetch_pending
);

  fetch_state_t           r_state;
  logic [PC_WIDTH-1:0]    r_pc;
  logic [INSTR_WIDTH-1:0] r_hold;

  logic                   w_accept;
  logic                   w_redirect;
  logic                   w_deliver;
  logic                   w_if_id_bubble;
  logic [PC_WIDTH-1:0]    w_pc_plus4;
  logic [PC_WIDTH-1:0]    w_target;
  logic [INSTR_WIDTH-1:0] w_deliver_instr;

  assign w_accept   = pc_write & IF_ID_write;
  assign w_redirect = flush & w_accept;
  assign w_pc_plus4 = r_pc + PC_WIDTH'(32'd4);

  always_comb begin
    w_target = w_pc_plus4;
    case (pc_source)
      PCSRC_SEQ:    w_target = w_pc_plus4;
      PCSRC_BRANCH: w_target = branch_target;
      PCSRC_JUMP:   w_target = jump_target;
      default:      w_target = w_pc_plus4;
    endcase
  end

  // An instruction reaches IF/ID only from a live response or the hold buffer.
  always_comb begin
    w_deliver       = 1'b0;
    w_deliver_instr = r_hold;
    if (w_accept && !w_redirect) begin
      if (r_state == WAIT && imem_rvalid) begin
        w_deliver       = 1'b1;
        w_deliver_instr = imem_rdata;
      end else if (r_state == HOLD) begin
        w_deliver = 1'b1;
      end
    end
  end

  assign w_if_id_bubble = IF_ID_write & ~w_deliver;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_hold  <= '0;
    end else begin
      if (w_redirect) begin
        r_pc <= w_target;
      end else if (w_deliver) begin
        r_pc <= w_pc_plus4;
      end

      case (r_state)
        IDLE: r_state <= REQ;
        REQ: begin
          // A redirect racing an accepted request leaves a stale response to drain.
          if (imem_ready) begin
            r_state <= w_redirect ? DROP : WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (w_redirect || w_deliver) begin
              r_state <= REQ;
            end else begin
              r_hold  <= imem_rdata;
              r_state <= HOLD;
            end
          end else if (w_redirect) begin
            r_state <= DROP;
          end
        end
        HOLD: begin
          if (w_redirect || w_deliver) begin
            r_hold  <= '0;
            r_state <= REQ;
          end
        end
        DROP: begin
          if (imem_rvalid) begin
            r_state <= REQ;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign imem_req      = (r_state == REQ);
  assign imem_addr     = r_pc;
  assign fetch_pending = state_is_pending(r_state);

  if_id_reg #(
    .PC_WIDTH    (PC_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_deliver),
    .i_bubble   (w_if_id_bubble),
    .i_instr    (w_deliver_instr),
    .i_pc_plus4 (w_pc_plus4),
    .o_instr    (if_id_instr),
    .o_pc_plus4 (if_id_pc_plus4),
    .o_valid    (if_id_valid)
  );

  // A flush during a stall is dropped by the hardware; the hazard unit should never do that.
  a_flush_needs_accept: assert property (
    @(posedge clk) disable iff (!rst_n) !(flush && !w_accept)
  );

  a_addr_stable: assert property (
    @(posedge clk) disable iff (!rst_n)
      (imem_req && !imem_ready && !w_redirect) |=> $stable(imem_addr)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: scoreboard of expected IF/ID loads plus inline state checks.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write;
  logic        IF_ID_write;
  logic        flush;
  logic [1:0]  pc_source;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        fetch_pending;

  always #5 clk = ~clk;

  if_fetch_stage #(
    .PC_WIDTH    (32),
    .INSTR_WIDTH (32),
    .RESET_PC    (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_write       (pc_write),
    .IF_ID_write    (IF_ID_write),
    .flush          (flush),
    .pc_source      (pc_source),
    .branch_target  (branch_target),
    .jump_target    (jump_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .fetch_pending  (fetch_pending)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic expect_load(input logic [31:0] instr, input logic [31:0] pc4);
    exp_t e;
    e.instr = instr;
    e.pc4   = pc4;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0:   mem_rd = 32'h8C01_0004;
      32'h4:   mem_rd = 32'h0022_1820;
      default: mem_rd = 32'hA000_0000 | a;
    endcase
  endfunction

  // Memory: response arrives mem_lat cycles after acceptance (1 = next cycle).
  int          mem_lat;
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_busy    <= 1'b0;
      mem_cnt     <= 0;
      mem_addr_q  <= '0;
      imem_rvalid <= 1'b0;
      imem_rdata  <= '0;
    end else begin
      imem_rvalid <= 1'b0;
      if (mem_busy) begin
        if (mem_cnt <= 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= mem_rd(mem_addr_q);
          mem_busy    <= 1'b0;
        end else begin
          mem_cnt <= mem_cnt - 1;
        end
      end
      if (imem_req && imem_ready) begin
        if (mem_lat <= 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= mem_rd(imem_addr);
        end else begin
          mem_busy   <= 1'b1;
          mem_cnt    <= mem_lat - 1;
          mem_addr_q <= imem_addr;
        end
      end
    end
  end

  // Monitor: a new IF/ID entry is one seen valid after an edge where IF_ID_write was high.
  logic iw_q = 1'b0;
  int   cyc = 0;
  int   last_load_cyc = -1;
  int   last_gap = 0;

  always @(posedge clk) begin
    iw_q <= IF_ID_write;
    cyc  <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst_n && iw_q && if_id_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_load: got instr=%h pc4=%h, want no load", if_id_instr, if_id_pc_plus4);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ifid_instr", if_id_instr, mon_e.instr);
        chk("ifid_pc4", if_id_pc_plus4, mon_e.pc4);
      end
      if (last_load_cyc >= 0) last_gap = cyc - last_load_cyc;
      last_load_cyc = cyc;
    end
  end

  initial begin
    rst_n         = 1'b0;
    pc_write      = 1'b1;
    IF_ID_write   = 1'b1;
    flush         = 1'b0;
    pc_source     = 2'd0;
    branch_target = '0;
    jump_target   = '0;
    imem_ready    = 1'b1;
    mem_lat       = 1;

    tick(2);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(if_id_valid), 32'd0);
    chk("rst_instr", if_id_instr, 32'h0);
    chk("rst_pc4", if_id_pc_plus4, 32'h0);
    chk("rst_pending", 32'(fetch_pending), 32'd0);

    expect_load(32'h8C01_0004, 32'h4);
    rst_n = 1'b1;
    tick(1);
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    chk("first_pending", 32'(fetch_pending), 32'd1);
    tick(1);
    chk("wait_req", 32'(imem_req), 32'd0);
    chk("wait_bubble", 32'(if_id_valid), 32'd0);
    tick(1);
    pc_write    = 1'b0;
    IF_ID_write = 1'b0;

    // Stall while the 0x4 response returns: it must park in HOLD.
    tick(2);
    chk("hold_pending", 32'(fetch_pending), 32'd0);
    chk("hold_req", 32'(imem_req), 32'd0);
    chk("hold_ifid_valid", 32'(if_id_valid), 32'd1);
    chk("hold_ifid_instr", if_id_instr, 32'h8C01_0004);
    chk("hold_ifid_pc4", if_id_pc_plus4, 32'h4);
    chk("hold_pc", imem_addr, 32'h4);
    tick(1);
    chk("hold2_pc", imem_addr, 32'h4);
    chk("hold2_ifid_instr", if_id_instr, 32'h8C01_0004);
    expect_load(32'h0022_1820, 32'h8);
    expect_load(32'hA000_0008, 32'hC);
    pc_write    = 1'b1;
    IF_ID_write = 1'b1;
    tick(1);
    chk("post_hold_req", 32'(imem_req), 32'd1);
    chk("post_hold_addr", imem_addr, 32'h8);
    tick(1);
    mem_lat = 3;

    // Branch redirect while WAIT has no response yet.
    tick(2);
    chk("throughput_gap", 32'(last_gap), 32'd2);
    chk("pre_br_wait", 32'(imem_req), 32'd0);
    chk("pre_br_pending", 32'(fetch_pending), 32'd1);
    flush         = 1'b1;
    pc_source     = 2'd1;
    branch_target = 32'h40;
    tick(1);
    chk("br_bubble_valid", 32'(if_id_valid), 32'd0);
    chk("br_bubble_instr", if_id_instr, 32'h0);
    chk("br_bubble_pc4", if_id_pc_plus4, 32'h0);
    chk("br_drop_pending", 32'(fetch_pending), 32'd1);
    chk("br_drop_req", 32'(imem_req), 32'd0);
    chk("br_pc", imem_addr, 32'h40);
    flush     = 1'b0;
    pc_source = 2'd0;
    mem_lat   = 1;
    expect_load(32'hA000_0040, 32'h44);
    tick(1);
    chk("drop_pending", 32'(fetch_pending), 32'd1);
    chk("drop_req", 32'(imem_req), 32'd0);
    tick(1);
    chk("after_drop_req", 32'(imem_req), 32'd1);
    chk("after_drop_addr", imem_addr, 32'h40);
    tick(2);

    // Jump redirect in REQ with imem_ready low: re-presented, no DROP.
    imem_ready  = 1'b0;
    flush       = 1'b1;
    pc_source   = 2'd2;
    jump_target = 32'h100;
    tick(1);
    chk("jmp_req", 32'(imem_req), 32'd1);
    chk("jmp_addr", imem_addr, 32'h100);
    chk("jmp_bubble", 32'(if_id_valid), 32'd0);
    chk("jmp_pending", 32'(fetch_pending), 32'd1);
    flush     = 1'b0;
    pc_source = 2'd0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("stall_addr", imem_addr, 32'h100);
      chk("stall_req", 32'(imem_req), 32'd1);
      chk("stall_bubble", 32'(if_id_valid), 32'd0);
      chk("stall_pending", 32'(fetch_pending), 32'd1);
    end
    imem_ready = 1'b1;
    expect_load(32'hA000_0100, 32'h104);
    tick(2);
    mem_lat = 3;

    // Asynchronous reset in WAIT.
    tick(1);
    chk("pre_rst_wait", 32'(imem_req), 32'd0);
    chk("pre_rst_pending", 32'(fetch_pending), 32'd1);
    rst_n   = 1'b0;
    mem_lat = 1;
    #1;
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_valid", 32'(if_id_valid), 32'd0);
    chk("arst_instr", if_id_instr, 32'h0);
    chk("arst_pc4", if_id_pc_plus4, 32'h0);
    chk("arst_pending", 32'(fetch_pending), 32'd0);
    tick(2);
    expect_load(32'h8C01_0004, 32'h4);
    rst_n = 1'b1;
    tick(1);
    chk("rerst_req", 32'(imem_req), 32'd1);
    chk("rerst_addr", imem_addr, 32'h0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d loads outstanding, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the hazard unit.
- Owns the PC register, the single-outstanding instruction-memory request handshake and the IF/ID pipeline register.
- Consumes the hazard unit's pc_write, IF_ID_write, flush and pc_source outputs.
- Produces the IF/ID instruction, PC+4 and valid bit seen by decode and hazard detection.

Parameters:
- PC_WIDTH, 32, width of PC and memory address.
- INSTR_WIDTH, 32, instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_write  in  1  hazard unit: PC may advance.
- IF_ID_write  in  1  hazard unit: IF/ID may load.
- flush  in  1  hazard unit: redirect and bubble IF/ID.
- pc_source  in  2  redirect select: 0 = PC+4, 1 = branch_target, 2 = jump_target, 3 = PC+4.
- branch_target  in  PC_WIDTH  branch destination from ID.
- jump_target  in  PC_WIDTH  jump destination from ID.
- imem_req  out  1  fetch request valid.
- imem_addr  out  PC_WIDTH  fetch address, equal to PC.
- imem_ready  in  1  memory accepts request this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  INSTR_WIDTH  fetched instruction.
- if_id_instr  out  INSTR_WIDTH  IF/ID instruction; NOP (0) when bubble.
- if_id_pc_plus4  out  PC_WIDTH  IF/ID PC+4.
- if_id_valid  out  1  IF/ID holds a real instruction.
- fetch_pending  out  1  high in the REQ, WAIT and DROP states.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - PC = RESET_PC, state = IDLE.
  - imem_req = 0.
  - if_id_instr = 0, if_id_pc_plus4 = 0, if_id_valid = 0.
  - Hold buffer cleared.
- accept = pc_write & IF_ID_write.
- Redirect = flush & accept. If flush is asserted while accept = 0, flush is ignored; a simulation assertion flags it.
- Redirect target: pc_source 1 selects branch_target, 2 selects jump_target, 0 or 3 selects PC+4.
- States:
  - IDLE: imem_req = 0. Next cycle goes to REQ.
  - REQ: imem_req = 1, imem_addr = PC. On imem_ready, go to WAIT.
  - WAIT: imem_req = 0, waiting for imem_rvalid. Response latency is at least 1 cycle after acceptance and unbounded.
  - HOLD: instruction captured in the hold buffer, waiting for accept.
  - DROP: stale response outstanding. On imem_rvalid, discard the data and go to REQ.
- WAIT with imem_rvalid and accept, no redirect:
  - IF/ID loads {imem_rdata, PC+4}, valid = 1.
  - PC = PC+4 (mod 2^PC_WIDTH), go to REQ.
- WAIT with imem_rvalid and accept = 0: capture imem_rdata in the hold buffer, go to HOLD. PC and IF/ID unchanged.
- HOLD with accept, no redirect: IF/ID loads {hold, PC+4}, valid = 1. PC = PC+4, go to REQ.
- No instruction available (IDLE, REQ, WAIT without rvalid, DROP) with IF_ID_write = 1: IF/ID loads a bubble (instr = 0, valid = 0, pc_plus4 = 0).
- IF_ID_write = 0: IF/ID holds its value.
- On redirect:
  - IF/ID becomes a bubble.
  - PC = redirect target.
  - Next state depends on the current state:
    - REQ without imem_ready: stay in REQ; the request is re-presented with the new address next cycle.
    - REQ with imem_ready in the same cycle: go to DROP, because the old request was accepted.
    - WAIT without rvalid: go to DROP.
    - WAIT with rvalid: discard the data, go to REQ.
    - HOLD: discard the buffer, go to REQ.
    - DROP: stay in DROP. If rvalid arrives in the same cycle, go to REQ.
- Throughput: at most 1 instruction per 2 cycles with a 1-cycle memory. Only one request is ever outstanding.
- imem_addr is stable while imem_req = 1 and imem_ready = 0, except on redirect.

Decomposition:
- Package if_pkg:
  - fetch_state_t enum {IDLE, REQ, WAIT, HOLD, DROP}.
  - PCSRC_SEQ = 0, PCSRC_BRANCH = 1, PCSRC_JUMP = 2.
  - NOP_INSTR = 32'h0.
- Sub-module if_id_reg: IF/ID pipeline register with load / hold / bubble controls, asynchronous active-low reset.

Test Plan:
- Reset then release, memory with ready = 1 and 1-cycle rvalid returning 0x8C010004 at 0x0, 0x00221820 at 0x4:
  - cycle 1: imem_req = 1, addr = 0x0.
  - IF/ID then shows valid = 1, instr 0x8C010004, pc_plus4 0x4.
  - the next instruction follows 2 cycles later.
- Hold accept low (pc_write = IF_ID_write = 0) when rvalid returns 0x00221820 at PC 0x4:
  - state goes to HOLD; IF/ID unchanged; PC stays 0x4.
  - release accept: IF/ID gets 0x00221820 with pc_plus4 0x8.
- flush = 1, pc_source = 1, branch_target = 0x40 while in WAIT:
  - IF/ID becomes a bubble; state goes to DROP.
  - the stale rdata is discarded; the next imem_addr is 0x40.
- flush = 1, pc_source = 2, jump_target = 0x100 in REQ with imem_ready = 0:
  - the next-cycle request is addr 0x100; no DROP.
- imem_ready held 0 for 5 cycles:
  - imem_addr stays constant; IF/ID shows bubbles; fetch_pending = 1.
- Assert rst_n = 0 in WAIT, then release:
  - all outputs go to reset values immediately.
  - the first request after release is RESET_PC.
